// File: rtl/rv_dmem_resp.sv
// rv_dmem_resp: data-memory responder for the multicycle RISC-V core.
// Accepts one word load/store at a time, holds it for LATENCY cycles,
// then completes it with a one-cycle ready pulse and an error flag.
// Storage is split into four byte-lane arrays so byte-enable writes map
// directly onto byte-wide memories.
module rv_dmem_resp #(
   parameter int DPWIDTH = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               dmem_req,
   input  logic               dmem_we,
   input  logic [3:0]         dmem_be,
   input  logic [DPWIDTH-1:0] dmem_addr,
   input  logic [DPWIDTH-1:0] dmem_dataout,
   output logic [DPWIDTH-1:0] dmem_datain,
   output logic               dmem_ready,
   output logic               dmem_err
);

   localparam int AW = $clog2(DEPTH);

   // Reject illegal configurations at elaboration time.
   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("rv_dmem_resp: LATENCY must be in 1..15");
      end
      if (DPWIDTH != 32) begin : g_bad_width
         $error("rv_dmem_resp: DPWIDTH must be 32");
      end
      if ((1 << AW) != DEPTH) begin : g_bad_depth
         $error("rv_dmem_resp: DEPTH must be a power of two");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 accept;
   logic                 fire;
   logic                 we_q;
   logic [3:0]           be_q;
   logic [DPWIDTH-1:0]   addr_q;
   logic [DPWIDTH-1:0]   wdata_q;
   logic [DPWIDTH-1:0]   rdata_q;
   logic                 ready_q;
   logic                 err_q;
   logic [AW-1:0]        idx;
   logic                 bad_addr;
   logic                 wr_en;
   logic [DPWIDTH-1:0]   rd_word;

   assign idx      = addr_q[AW+1:2];
   assign bad_addr = (addr_q[1:0] != 2'b00) || (addr_q[DPWIDTH-1:AW+2] != '0);
   // Reset wins over a completion on the same edge, so it also gates the write.
   assign wr_en    = rst && fire && we_q && !bad_addr;

   // Next-state logic: accept in IDLE/DONE, count down in BUSY, complete at zero.
   // LATENCY=1 loads a zero count and spends exactly one cycle in BUSY, which
   // keeps the ready pulse one edge after accept and non-continuous back-to-back.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      fire    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (dmem_req) begin
               accept  = 1'b1;
               state_d = BUSY;
               cnt_d   = 4'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               fire    = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counter, request latch and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= fire;
         err_q   <= fire && bad_addr;
         if (fire && !we_q) begin
            rdata_q <= bad_addr ? '0 : rd_word;
         end
         if (accept) begin
            we_q    <= dmem_we;
            be_q    <= dmem_be;
            addr_q  <= dmem_addr;
            wdata_q <= dmem_dataout;
         end
      end
   end

   // One byte-wide array per lane; contents are deliberately not reset.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_q [DEPTH];

         // Lane write on completion when this lane's enable is set.
         always_ff @(posedge clk) begin
            if (wr_en && be_q[gi]) begin
               lane_q[idx] <= wdata_q[8*gi +: 8];
            end
         end

         assign rd_word[8*gi +: 8] = lane_q[idx];
      end
   endgenerate

   assign dmem_datain = rdata_q;
   assign dmem_ready  = ready_q;
   assign dmem_err    = err_q;

endmodule

// File: tb/tb_rv_dmem_resp.sv
// Directed bench for rv_dmem_resp: three instances (LATENCY 2, 1, 3) share
// reset and request fields but each has its own request strobe.
module tb_rv_dmem_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        req1, req2, req3;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr, wdata;
   logic [31:0] dout1, dout2, dout3;
   logic        rdy1, rdy2, rdy3;
   logic        err1, err2, err3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv_dmem_resp #(.DPWIDTH(32), .DEPTH(1024), .LATENCY(2)) dut2 (
      .clk(clk), .rst(rst), .dmem_req(req2), .dmem_we(we), .dmem_be(be),
      .dmem_addr(addr), .dmem_dataout(wdata), .dmem_datain(dout2),
      .dmem_ready(rdy2), .dmem_err(err2));

   rv_dmem_resp #(.DPWIDTH(32), .DEPTH(1024), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .dmem_req(req1), .dmem_we(we), .dmem_be(be),
      .dmem_addr(addr), .dmem_dataout(wdata), .dmem_datain(dout1),
      .dmem_ready(rdy1), .dmem_err(err1));

   rv_dmem_resp #(.DPWIDTH(32), .DEPTH(1024), .LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .dmem_req(req3), .dmem_we(we), .dmem_be(be),
      .dmem_addr(addr), .dmem_dataout(wdata), .dmem_datain(dout3),
      .dmem_ready(rdy3), .dmem_err(err3));

   task automatic set_req(input int sel, input logic v);
      case (sel)
         1: req1 = v;
         3: req3 = v;
         default: req2 = v;
      endcase
   endtask

   function automatic logic get_rdy(input int sel);
      case (sel)
         1: return rdy1;
         3: return rdy3;
         default: return rdy2;
      endcase
   endfunction

   function automatic logic [31:0] get_dout(input int sel);
      case (sel)
         1: return dout1;
         3: return dout3;
         default: return dout2;
      endcase
   endfunction

   function automatic logic get_err(input int sel);
      case (sel)
         1: return err1;
         3: return err3;
         default: return err2;
      endcase
   endfunction

   // Issue one request on instance sel and wait (bounded) for its ready pulse.
   // lat = number of edges after the accept edge; 99 when no pulse appeared.
   task automatic op(input int sel, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e);
      we = w; be = b; addr = a; wdata = d;
      set_req(sel, 1'b1);
      @(posedge clk); #1;
      set_req(sel, 1'b0);
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (get_rdy(sel)) begin
            lat = i;
            break;
         end
      end
      rd = get_dout(sel);
      e  = get_err(sel);
      $display("txn lat%0d we=%0b be=%h addr=%h wdata=%h -> cycles=%0d datain=%h err=%0b",
               (sel == 2) ? 2 : sel, w, b, a, d, lat, rd, e);
   endtask

   task automatic test_reset();
      rst = 1'b0; req1 = 0; req2 = 0; req3 = 0;
      we = 0; be = 4'h0; addr = 0; wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", rdy2); end
      total++; if (err2 !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err2); end
      total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL reset_datain got=%h want=0", dout2); end
      total++; if ({rdy1, rdy3} !== 2'b00) begin bad++; $display("FAIL reset_ready_other got=%b want=00", {rdy1, rdy3}); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] rd; logic e;
      op(2, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL store_latency got=%0d want=2", lat); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", e); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_datain_hold got=%h want=0", rd); end
      op(2, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL load_latency got=%0d want=2", lat); end
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", rd); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", e); end
      @(posedge clk); #1;
      total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL ready_single_pulse got=%b want=0", rdy2); end
      total++; if (dout2 !== 32'hDEADBEEF) begin bad++; $display("FAIL datain_hold got=%h want=deadbeef", dout2); end
   endtask

   task automatic test_byte_enables();
      int lat; logic [31:0] rd; logic e;
      op(2, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, lat, rd, e);
      op(2, 1'b1, 4'b0101, 32'h20, 32'h11223344, lat, rd, e);
      total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL store_keeps_datain got=%h want=deadbeef", rd); end
      op(2, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, e);
      total++; if (rd !== 32'hFF22FF44) begin bad++; $display("FAIL be_merge got=%h want=ff22ff44", rd); end
      op(2, 1'b1, 4'h0, 32'h20, 32'hAAAAAAAA, lat, rd, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL be0_latency got=%0d want=2", lat); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL be0_err got=%b want=0", e); end
      op(2, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd, e);
      total++; if (rd !== 32'hFF22FF44) begin bad++; $display("FAIL be0_no_write got=%h want=ff22ff44", rd); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic e;
      op(2, 1'b0, 4'h0, 32'h22, 32'h0, lat, rd, e);
      total++; if (lat !== 2) begin bad++; $display("FAIL misalign_latency got=%0d want=2", lat); end
      total++; if (e !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", e); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL misalign_datain got=%h want=0", rd); end
      // Word 0 aliases 4*DEPTH if the range check were missing.
      op(2, 1'b1, 4'hF, 32'h0, 32'h01020304, lat, rd, e);
      op(2, 1'b1, 4'hF, 32'h1000, 32'h55555555, lat, rd, e);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL oob_store_err got=%b want=1", e); end
      op(2, 1'b0, 4'h0, 32'h0, 32'h0, lat, rd, e);
      total++; if (rd !== 32'h01020304) begin bad++; $display("FAIL oob_no_write got=%h want=01020304", rd); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL readback_err got=%b want=0", e); end
   endtask

   task automatic test_ignored_req();
      int pulses;
      logic [31:0] seen;
      seen = 32'h0;
      we = 1'b0; be = 4'h0; addr = 32'h10; wdata = 32'h0;
      req2 = 1'b1;
      @(posedge clk); #1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         req2 = (i == 0);   // high only across the first BUSY edge
         @(posedge clk); #1;
         if (rdy2) begin
            pulses++;
            seen = dout2;
         end
      end
      req2 = 1'b0;
      $display("txn busy-toggle load addr=00000010 -> pulses=%0d datain=%h", pulses, seen);
      total++; if (pulses !== 1) begin bad++; $display("FAIL busy_req_ignored pulses=%0d want=1", pulses); end
      total++; if (seen !== 32'hDEADBEEF) begin bad++; $display("FAIL busy_req_data got=%h want=deadbeef", seen); end
   endtask

   task automatic test_back_to_back(input int sel, input int lat_cfg, input logic [31:0] base);
      int lat; logic [31:0] rd; logic e;
      int cyc, last, k;
      logic [31:0] exp_val;
      for (int j = 0; j < 3; j++) begin
         op(sel, 1'b1, 4'hF, base + 32'(4 * j), 32'hC0DE0000 + base + 32'(j), lat, rd, e);
      end
      total++; if (lat !== lat_cfg) begin bad++; $display("FAIL b2b_store_latency L%0d got=%0d want=%0d", lat_cfg, lat, lat_cfg); end
      we = 1'b0; be = 4'h0; addr = base;
      set_req(sel, 1'b1);
      @(posedge clk); #1;
      cyc = 0; last = 0; k = 0;
      while (k < 3 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (get_rdy(sel)) begin
            exp_val = 32'hC0DE0000 + base + 32'(k);
            $display("txn b2b L%0d load addr=%h -> cycle=%0d datain=%h", lat_cfg, base + 32'(4 * k), cyc, get_dout(sel));
            total++; if (get_dout(sel) !== exp_val) begin bad++; $display("FAIL b2b_data L%0d k=%0d got=%h want=%h", lat_cfg, k, get_dout(sel), exp_val); end
            total++;
            if ((k == 0) ? (cyc != lat_cfg) : (cyc - last != lat_cfg + 1)) begin
               bad++; $display("FAIL b2b_spacing L%0d k=%0d got_cycle=%0d prev=%0d want_gap=%0d", lat_cfg, k, cyc, last, lat_cfg + 1);
            end
            last = cyc;
            k++;
            addr = base + 32'(4 * k);
            if (k == 3) set_req(sel, 1'b0);
         end
      end
      set_req(sel, 1'b0);
      total++; if (k !== 3) begin bad++; $display("FAIL b2b_count L%0d got=%0d want=3", lat_cfg, k); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_abort();
      int lat; logic [31:0] rd; logic e;
      int pulses;
      op(2, 1'b1, 4'hF, 32'h40, 32'h12345678, lat, rd, e);
      op(2, 1'b0, 4'h0, 32'h40, 32'h0, lat, rd, e);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL abort_preload got=%h want=12345678", rd); end
      we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'hCAFEF00D;
      req2 = 1'b1;
      @(posedge clk); #1;          // accepted, BUSY count 1
      req2 = 1'b0;
      @(posedge clk); #1;          // BUSY count 0: next edge would complete
      rst = 1'b0;
      @(posedge clk); #1;
      $display("txn reset-abort store addr=00000040 -> ready=%b err=%b datain=%h", rdy2, err2, dout2);
      total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL abort_ready got=%b want=0", rdy2); end
      total++; if (err2 !== 1'b0) begin bad++; $display("FAIL abort_err got=%b want=0", err2); end
      total++; if (dout2 !== 32'h0) begin bad++; $display("FAIL abort_datain got=%h want=0", dout2); end
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (rdy2) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL abort_late_pulse pulses=%0d want=0", pulses); end
      op(2, 1'b0, 4'h0, 32'h40, 32'h0, lat, rd, e);
      total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL abort_no_write got=%h want=12345678", rd); end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_enables();
      test_errors();
      test_ignored_req();
      test_back_to_back(1, 1, 32'h100);
      test_back_to_back(3, 3, 32'h200);
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
